// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains an async FIFO's read port one word per frame:
// start bit, LSB-first data, optional even parity, then one or two stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parity_q, parity_d;
    logic                    done_q, done_d;
    logic                    period_end;

    assign period_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                // rdata is valid now, one cycle after the pop strobe
                shift_d  = fifo_rdata;
                parity_d = ^fifo_rdata;
                state_d  = START;
            end
            START: begin
                if (period_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (period_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (period_end) begin
                    if (bit_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = (tx_en && !fifo_empty) ? FETCH : IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Both counters restart on any state change so each phase starts from zero
        if (state_d != state_q) begin
            baud_d = '0;
            bit_d  = '0;
        end else if (state_q inside {START, DATA, PARITY, STOP}) begin
            baud_d = period_end ? '0 : baud_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            PARITY:  tx = parity_q;
            default: tx = 1'b1;
        endcase
    end

    assign fifo_rinc  = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule
